// File: rtl/vga_sync_if.sv
// Raster timing bundle driven by vga_sync_timing and consumed by the pixel
// colour stage.
interface vga_sync_if;
    logic       oPixel_Enable;
    logic [9:0] oColumn;
    logic [9:0] oRow;
    logic       oVideo_On;
    logic       oHorizontal_Sync;
    logic       oVertical_Sync;
    logic       oFrame_Start;
    logic [7:0] oFrame_Count;

    modport master (
        output oPixel_Enable, oColumn, oRow, oVideo_On,
               oHorizontal_Sync, oVertical_Sync, oFrame_Start, oFrame_Count
    );

    modport slave (
        input  oPixel_Enable, oColumn, oRow, oVideo_On,
               oHorizontal_Sync, oVertical_Sync, oFrame_Start, oFrame_Count
    );
endinterface

// File: rtl/vga_sync_timing.sv
// Parameterised VGA raster timing generator (pixel tick, syncs, coordinates).
// Define VGA_SYNC_FRAME_COUNT_EN to enable the 8-bit frame counter.
module vga_sync_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    vga_sync_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_col;
    logic [9:0]       r_row;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video;
    logic             r_frame_start;

    logic             w_pix_en;
    logic [9:0]       w_col_nxt;
    logic [9:0]       w_row_nxt;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             w_video_nxt;
    logic             w_frame_start_nxt;

    assign w_pix_en = (r_div == DIV_LAST);

    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (w_pix_en) begin
            if (r_col == H_LAST) begin
                w_col_nxt = '0;
                w_row_nxt = (r_row == V_LAST) ? '0 : r_row + 10'd1;
            end else begin
                w_col_nxt = r_col + 10'd1;
            end
        end
    end

    // Decode from the next coordinates so every registered output lines up
    // with the counters on the same edge.
    assign w_hsync_nxt = !(({1'b0, w_col_nxt} >= H_SYNC_BEG) && ({1'b0, w_col_nxt} < H_SYNC_END));
    assign w_vsync_nxt = !(({1'b0, w_row_nxt} >= V_SYNC_BEG) && ({1'b0, w_row_nxt} < V_SYNC_END));
    assign w_video_nxt = ({1'b0, w_col_nxt} < H_VIS_END) && ({1'b0, w_row_nxt} < V_VIS_END);
    assign w_frame_start_nxt = w_pix_en && (w_col_nxt == 10'd0) && (w_row_nxt == 10'd0);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_div         <= '0;
            r_col         <= H_LAST;
            r_row         <= V_LAST;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_pix_en ? '0 : r_div + DIV_W'(1);
            r_col         <= w_col_nxt;
            r_row         <= w_row_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_video       <= w_video_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

`ifdef VGA_SYNC_FRAME_COUNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_frame_cnt <= 8'd0;
        end else if (w_frame_start_nxt) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign vga.oFrame_Count = r_frame_cnt;
`else
    assign vga.oFrame_Count = 8'd0;
`endif

    assign vga.oPixel_Enable    = w_pix_en;
    assign vga.oColumn          = r_col;
    assign vga.oRow             = r_row;
    assign vga.oVideo_On        = r_video;
    assign vga.oHorizontal_Sync = r_hsync;
    assign vga.oVertical_Sync   = r_vsync;
    assign vga.oFrame_Start     = r_frame_start;
endmodule

// File: doc/vga_sync_timing.md
# vga_sync_timing

Generates 640x480@60 Hz VGA raster timing from the board clock: a pixel-rate enable, horizontal/vertical sync, visible-area flag and current pixel coordinates. Sits directly upstream of Module_VGA_Control, which uses oColumn/oRow/oVideo_On to produce oVGA_R/G/B and forwards the sync signals to the connector. All timing is parameterised. Defaults target the 50 MHz Spartan-3E clock with a 25 MHz pixel rate.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, Clock cycles per pixel (≥1)
- Clock  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- oPixel_Enable  output  1  pixel tick, high 1 Clock cycle in every CLK_DIV
- oColumn  output  10  current pixel column, 0..H_TOTAL-1
- oRow  output  10  current line, 0..V_TOTAL-1
- oVideo_On  output  1  high when oColumn<H_VISIBLE and oRow<V_VISIBLE
- oHorizontal_Sync  output  1  active-low hsync
- oVertical_Sync  output  1  active-low vsync
- oFrame_Start  output  1  one-Clock pulse on entering (0,0)
- oFrame_Count  output  8  frame counter (see Configuration)

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525). Both must be ≤1024. Counters are fixed at 10 bits.
- Divider counts 0..CLK_DIV-1 and wraps. oPixel_Enable = (divider == CLK_DIV-1), combinational from the registered divider. CLK_DIV=1 makes oPixel_Enable constant high out of reset.
- On each Clock edge with oPixel_Enable high, oColumn increments.
  - oColumn = H_TOTAL-1 wraps to 0 and increments oRow.
  - oRow = V_TOTAL-1 at that wrap also wraps to 0.
- Decodes are computed from the next counter values and registered on the same edge, so all outputs are mutually aligned with zero skew:
  - oHorizontal_Sync low iff H_VISIBLE+H_FRONT ≤ column < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - oVertical_Sync low iff V_VISIBLE+V_FRONT ≤ row < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - oVideo_On as defined in Interface.
- oFrame_Start is registered high for exactly one Clock cycle after the edge on which the counters move to (0,0). Otherwise low.
- Reset (Reset=0) asynchronously forces:
  - divider=0
  - oColumn=H_TOTAL-1 (799), oRow=V_TOTAL-1 (524)
  - oHorizontal_Sync=1, oVertical_Sync=1, oVideo_On=0, oFrame_Start=0, oFrame_Count=0
  - These values are consistent with the decode at (799,524). The first tick after release therefore lands on (0,0) and starts a clean frame.
- Reset asserted mid-line or mid-frame aborts immediately. No partial-state retention.

## Timing
- Reset release to first oPixel_Enable: CLK_DIV-1 Clock cycles after the first rising edge with Reset=1.
- Counter/decode update latency: the edge ending the oPixel_Enable cycle.
- Line period: H_TOTAL×CLK_DIV = 1600 Clocks.
- Frame period: H_TOTAL×V_TOTAL×CLK_DIV = 840000 Clocks (16.8 ms).
- hsync low for 96×CLK_DIV = 192 Clocks. vsync low for 2 lines = 3200 Clocks.
- Vsync edges coincide with the column wrap to 0 (same edge as the hsync line boundary).
- Consumers sample oColumn/oRow/oVideo_On when oPixel_Enable is high. Values are stable for the whole pixel period.

## Configuration
- VGA_SYNC_FRAME_COUNT_EN defined:
  - oFrame_Count increments (mod 256) on every edge that asserts oFrame_Start, including the first frame after reset.
  - Used by Module_VGA_Control for animated test patterns.
- Undefined: oFrame_Count is tied to 8'd0 and no counter logic is synthesised.

## Test plan
- Hold Reset=0 for 5 Clocks -> oColumn=799, oRow=524, both syncs=1, oVideo_On=0, oFrame_Start=0.
- Release reset, CLK_DIV=2 -> oPixel_Enable high on 2nd Clock cycle. Next edge gives (0,0), oVideo_On=1, oFrame_Start pulse of 1 Clock.
- Free-run one line -> oHorizontal_Sync falls at column 656 and stays low 192 Clocks. oVideo_On low for columns 640..799. Line period 1600 Clocks.
- Free-run two frames -> oVertical_Sync low only on rows 490..491 (3200 Clocks). oFrame_Start pulses exactly 840000 Clocks apart.
- Assert Reset at row 100, column 300 -> outputs return to reset values within the same cycle, and the first frame after release restarts at (0,0).
- With VGA_SYNC_FRAME_COUNT_EN, run 257 frames -> oFrame_Count reads 1 after wrap. Without the macro it stays 0.
